alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; must match the attached ALU.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid_i / req1_valid_i  input  1  requester N has an operation pending.
REQ-005 SHALL have ports req0_ready_o / req1_ready_o  output  1  operation accepted when valid and ready are both high.
REQ-006 SHALL have ports reqN_a_i / reqN_b_i  input  WIDTH, and reqN_op_i  input  3, per requester: operands and opcode.
REQ-007 SHALL have ports rsp0_valid_o / rsp1_valid_o  output  1  response available to requester N.
REQ-008 SHALL have ports rsp0_ready_i / rsp1_ready_i  input  1  requester N consumes its response.
REQ-009 SHALL have ports rspN_result_o  output  WIDTH, and rspN_flags_o  output  3: {error, carry, zero}.
REQ-010 SHALL have ports alu_a_o / alu_b_o  output  WIDTH, and alu_op_o  output  3, driving the ALU.
REQ-011 SHALL have ports alu_result_i  input  WIDTH, and alu_carry_i / alu_error_i / alu_zero_i  input  1, from the ALU; alu_zero_i is registered inside the ALU.
REQ-012 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, EXEC, ZWAIT, RESP.
REQ-014 IDLE: reqN_ready_o SHALL be high combinationally only for the granted requester, and only while that requester's valid is high; all other ready outputs low.
REQ-015 IDLE, on handshake: SHALL register a, b, op onto alu_*_o, record the grant owner, and go to EXEC.
REQ-016 EXEC lasts 1 cycle: alu_*_o SHALL be held; alu_result_i, alu_carry_i and alu_error_i SHALL be captured at the end of the cycle; go to ZWAIT.
REQ-017 ZWAIT lasts 1 cycle: alu_*_o SHALL be held; alu_zero_i SHALL be captured at the end of the cycle (it reflects the EXEC result); go to RESP.
REQ-018 RESP: rspN_valid_o SHALL be high for the owner only; result and flags SHALL be stable until rspN_ready_i is high; on that handshake go to IDLE.
REQ-019 Latency: rsp_valid SHALL first rise 3 cycles after the accept cycle; maximum throughput is 1 operation per 4 cycles.
REQ-020 reqN_ready_o SHALL be low in EXEC, ZWAIT and RESP, so no new accept occurs while an operation is in flight.
REQ-021 Outside EXEC/ZWAIT, alu_*_o SHALL hold the last issued values.
REQ-022 Only one requester valid: that requester SHALL be granted, regardless of arbitration mode.
REQ-023 Response results SHALL pass through unmodified: no width extension; carry/borrow SHALL come from the ALU.

Reset
REQ-024 rst high at a clock edge SHALL force IDLE, clear the in-flight operation, and produce no response.
REQ-025 Reset values SHALL be: all ready/valid outputs 0, busy_o 0, alu_a_o/alu_b_o/alu_op_o 0, rspN_result_o 0, rspN_flags_o 0, RR pointer = 1 (requester 0 wins first).
REQ-026 Reset asserted mid-operation (EXEC/ZWAIT/RESP) SHALL give rsp_valid low in the next cycle, and the pending operation SHALL be lost.

Configuration
REQ-027 Macro ALU_ARB_RR_EN defined: round-robin; when both requesters are valid, the one not granted last SHALL win; the pointer SHALL update at accept only.
REQ-028 ALU_ARB_RR_EN undefined: fixed priority; requester 0 SHALL always win when valid, and the pointer logic SHALL be absent.

Verification
REQ-029 SHALL cover: req0 ADD a=0xF0 b=0x20 -> rsp0 result 0x10, flags 3'b010, rsp0_valid 3 cycles after accept.
REQ-030 SHALL cover: req1 SUB a=0x05 b=0x05 -> rsp1 result 0x00, flags 3'b001 (zero from ZWAIT capture).
REQ-031 SHALL cover: both valid continuously, ALU_ARB_RR_EN defined -> grant order 0,1,0,1; macro undefined -> grants 0,0,0,0.
REQ-032 SHALL cover: rsp0_ready_i low for 5 cycles in RESP -> rsp0_valid_o and result stable, req1_ready_o low throughout, req1 accepted in the IDLE cycle after the handshake.
REQ-033 SHALL cover: rst high during EXEC of SHL a=0x81 -> no response; next op SHL 0x81 -> result 0x02, flags 3'b000.

Source files
------------

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Two-requester front end for a shared ALU. One operation is in flight at a
// time: IDLE accepts a request, EXEC issues it and captures result/carry/error,
// ZWAIT captures the ALU's registered zero flag, RESP presents the response to
// the requester that issued the operation until it is consumed.
//
// Configuration macro: ALU_ARB_RR_EN
//   defined   -> round-robin arbitration between the two requesters
//   undefined -> fixed priority, requester 0 wins whenever it is valid
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   reqN_valid_i / reqN_ready_o      request handshake, N = 0,1
//   reqN_a_i, reqN_b_i, reqN_op_i    operands and opcode of requester N
//   rspN_valid_o / rspN_ready_i      response handshake, N = 0,1
//   rspN_result_o, rspN_flags_o      result and {error, carry, zero}
//   alu_a_o, alu_b_o, alu_op_o       operation driven to the ALU
//   alu_result_i, alu_carry_i,
//   alu_error_i, alu_zero_i          ALU outputs (zero is registered in the ALU)
//   busy_o                           high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,

   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [WIDTH-1:0] req0_a_i,
   input  logic [WIDTH-1:0] req0_b_i,
   input  logic [2:0]       req0_op_i,

   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [WIDTH-1:0] req1_a_i,
   input  logic [WIDTH-1:0] req1_b_i,
   input  logic [2:0]       req1_op_i,

   output logic             rsp0_valid_o,
   input  logic             rsp0_ready_i,
   output logic [WIDTH-1:0] rsp0_result_o,
   output logic [2:0]       rsp0_flags_o,

   output logic             rsp1_valid_o,
   input  logic             rsp1_ready_i,
   output logic [WIDTH-1:0] rsp1_result_o,
   output logic [2:0]       rsp1_flags_o,

   output logic [WIDTH-1:0] alu_a_o,
   output logic [WIDTH-1:0] alu_b_o,
   output logic [2:0]       alu_op_o,
   input  logic [WIDTH-1:0] alu_result_i,
   input  logic             alu_carry_i,
   input  logic             alu_error_i,
   input  logic             alu_zero_i,

   output logic             busy_o
);

   typedef enum logic [1:0] {StIdle, StExec, StZwait, StResp} state_e;

   state_e           r_state;
   logic             r_owner;      // requester that issued the in-flight operation
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [2:0]       r_alu_op;
   logic [WIDTH-1:0] r_result;
   logic             r_carry;
   logic             r_error;
   logic             r_zero;
   logic             r_rsp0_valid;
   logic             r_rsp1_valid;

   logic             w_idle;
   logic             w_grant1;     // requester 1 is the current arbitration winner
   logic             w_ready0;
   logic             w_ready1;
   logic             w_accept;
   logic             w_rsp_hs;

`ifdef ALU_ARB_RR_EN
   logic             r_rr_ptr;     // last requester granted; reset to 1 so requester 0 wins first

   always_comb begin
      if (req0_valid_i && req1_valid_i) begin
         w_grant1 = ~r_rr_ptr;
      end else begin
         w_grant1 = req1_valid_i;
      end
   end
`else
   assign w_grant1 = req1_valid_i & ~req0_valid_i;
`endif

   assign w_idle   = (r_state == StIdle);
   assign w_ready0 = w_idle & req0_valid_i & ~w_grant1;
   assign w_ready1 = w_idle & req1_valid_i &  w_grant1;
   assign w_accept = w_ready0 | w_ready1;
   assign w_rsp_hs = (r_rsp0_valid & rsp0_ready_i) | (r_rsp1_valid & rsp1_ready_i);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= StIdle;
         r_owner      <= 1'b0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_op     <= '0;
         r_result     <= '0;
         r_carry      <= 1'b0;
         r_error      <= 1'b0;
         r_zero       <= 1'b0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
`ifdef ALU_ARB_RR_EN
         r_rr_ptr     <= 1'b1;
`endif
      end else begin
         case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_alu_a  <= w_grant1 ? req1_a_i  : req0_a_i;
                  r_alu_b  <= w_grant1 ? req1_b_i  : req0_b_i;
                  r_alu_op <= w_grant1 ? req1_op_i : req0_op_i;
                  r_owner  <= w_grant1;
`ifdef ALU_ARB_RR_EN
                  r_rr_ptr <= w_grant1;
`endif
                  r_state  <= StExec;
               end
            end
            StExec: begin
               r_result <= alu_result_i;
               r_carry  <= alu_carry_i;
               r_error  <= alu_error_i;
               r_state  <= StZwait;
            end
            StZwait: begin
               // The ALU registers zero, so it reflects the EXEC operands only now.
               r_zero       <= alu_zero_i;
               r_rsp0_valid <= ~r_owner;
               r_rsp1_valid <=  r_owner;
               r_state      <= StResp;
            end
            StResp: begin
               if (w_rsp_hs) begin
                  r_rsp0_valid <= 1'b0;
                  r_rsp1_valid <= 1'b0;
                  r_state      <= StIdle;
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign req0_ready_o  = w_ready0;
   assign req1_ready_o  = w_ready1;

   assign rsp0_valid_o  = r_rsp0_valid;
   assign rsp1_valid_o  = r_rsp1_valid;
   assign rsp0_result_o = r_result;
   assign rsp1_result_o = r_result;
   assign rsp0_flags_o  = {r_error, r_carry, r_zero};
   assign rsp1_flags_o  = {r_error, r_carry, r_zero};

   assign alu_a_o       = r_alu_a;
   assign alu_b_o       = r_alu_b;
   assign alu_op_o      = r_alu_op;

   assign busy_o        = ~w_idle;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU attached.
// ALU opcodes used here: 0 ADD, 1 SUB (carry = borrow), 2 AND, 3 OR, 4 XOR,
// 5 SHL by 1, 6 SHR by 1, 7 illegal (error set, result 0).
module tb_alu_arbiter;
   localparam int W = 8;
   localparam logic [2:0] OpAdd = 3'd0;
   localparam logic [2:0] OpSub = 3'd1;
   localparam logic [2:0] OpAnd = 3'd2;
   localparam logic [2:0] OpShl = 3'd5;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid_i, req0_ready_o, req1_valid_i, req1_ready_o;
   logic [W-1:0] req0_a_i, req0_b_i, req1_a_i, req1_b_i;
   logic [2:0]   req0_op_i, req1_op_i;
   logic         rsp0_valid_o, rsp0_ready_i, rsp1_valid_o, rsp1_ready_i;
   logic [W-1:0] rsp0_result_o, rsp1_result_o;
   logic [2:0]   rsp0_flags_o, rsp1_flags_o;
   logic [W-1:0] alu_a_o, alu_b_o, alu_result_i;
   logic [2:0]   alu_op_o;
   logic         alu_carry_i, alu_error_i, alu_zero_i;
   logic         busy_o;
   logic [W+1:0] alu_out;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
      .req0_a_i(req0_a_i), .req0_b_i(req0_b_i), .req0_op_i(req0_op_i),
      .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
      .req1_a_i(req1_a_i), .req1_b_i(req1_b_i), .req1_op_i(req1_op_i),
      .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i),
      .rsp0_result_o(rsp0_result_o), .rsp0_flags_o(rsp0_flags_o),
      .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i),
      .rsp1_result_o(rsp1_result_o), .rsp1_flags_o(rsp1_flags_o),
      .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_op_o(alu_op_o),
      .alu_result_i(alu_result_i), .alu_carry_i(alu_carry_i),
      .alu_error_i(alu_error_i), .alu_zero_i(alu_zero_i),
      .busy_o(busy_o)
   );

   // Returns {error, carry, result}.
   function automatic logic [W+1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
      logic [W:0] s;
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; return {1'b0, s[W], s[W-1:0]}; end
         3'd1: return {1'b0, (a < b), a - b};
         3'd2: return {2'b00, a & b};
         3'd3: return {2'b00, a | b};
         3'd4: return {2'b00, a ^ b};
         3'd5: return {2'b00, a << 1};
         3'd6: return {2'b00, a >> 1};
         default: return {1'b1, 1'b0, {W{1'b0}}};
      endcase
   endfunction

   // Expected response flags {error, carry, zero} for an operation.
   function automatic logic [2:0] exp_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] op);
      logic [W+1:0] r;
      r = alu_fn(a, b, op);
      return {r[W+1], r[W], (r[W-1:0] == '0)};
   endfunction

   assign alu_out      = alu_fn(alu_a_o, alu_b_o, alu_op_o);
   assign alu_result_i = alu_out[W-1:0];
   assign alu_carry_i  = alu_out[W];
   assign alu_error_i  = alu_out[W+1];
   always_ff @(posedge clk) alu_zero_i <= (alu_result_i == '0);

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1'b1;
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
      repeat (2) tick;
      rst = 1'b0;
   endtask

   // Presents one request and returns once it has been accepted (or timed out).
   task automatic issue(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, output bit ok);
      ok = 1'b0;
      if (!who) begin
         req0_a_i = a; req0_b_i = b; req0_op_i = op; req0_valid_i = 1'b1;
      end else begin
         req1_a_i = a; req1_b_i = b; req1_op_i = op; req1_valid_i = 1'b1;
      end
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (who ? req1_ready_o : req0_ready_o) ok = 1'b1;
         tick;
      end
      if (!who) req0_valid_i = 1'b0; else req1_valid_i = 1'b0;
   endtask

   // Counts falling edges after the accept edge until the response appears.
   task automatic wait_rsp(input bit who, output int lat);
      lat = -1;
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk);
         if (who ? rsp1_valid_o : rsp0_valid_o) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic consume(input bit who);
      if (!who) rsp0_ready_i = 1'b1; else rsp1_ready_i = 1'b1;
      tick;
      rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
   endtask

   task automatic test_reset;
      do_reset;
      @(negedge clk);
      checks++;
      if ({req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, busy_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 00000",
                  {req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, busy_o});
      end
      checks++;
      if ({alu_a_o, alu_b_o, alu_op_o} !== '0) begin
         errors++;
         $display("FAIL reset_alu: got a=%h b=%h op=%h required 0", alu_a_o, alu_b_o, alu_op_o);
      end
      checks++;
      if ({rsp0_result_o, rsp0_flags_o, rsp1_result_o, rsp1_flags_o} !== '0) begin
         errors++;
         $display("FAIL reset_rsp: got %h/%b %h/%b required 0", rsp0_result_o, rsp0_flags_o,
                  rsp1_result_o, rsp1_flags_o);
      end
      tick;
   endtask

   task automatic test_add;
      bit ok;
      int lat;
      issue(1'b0, 8'hF0, 8'h20, OpAdd, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL add_accept: got no accept required accept"); end
      wait_rsp(1'b0, lat);
      checks++;
      if (lat != 3) begin errors++; $display("FAIL add_latency: got %0d required 3", lat); end
      checks++;
      if (rsp0_result_o !== 8'h10 || rsp0_flags_o !== 3'b010 || rsp1_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL add_rsp: got %h/%b rsp1v=%b required 10/010 rsp1v=0",
                  rsp0_result_o, rsp0_flags_o, rsp1_valid_o);
      end
      consume(1'b0);
      @(negedge clk);
      checks++;
      if (rsp0_valid_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL add_done: got valid=%b busy=%b required 0 0", rsp0_valid_o, busy_o);
      end
      tick;
   endtask

   task automatic test_sub_zero;
      bit ok;
      int lat;
      issue(1'b1, 8'h05, 8'h05, OpSub, ok);
      wait_rsp(1'b1, lat);
      checks++;
      if (!ok || lat != 3 || rsp1_result_o !== 8'h00 || rsp1_flags_o !== 3'b001 ||
          rsp0_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL sub_zero: got ok=%0d lat=%0d %h/%b required 1 3 00/001",
                  ok, lat, rsp1_result_o, rsp1_flags_o);
      end
      consume(1'b1);
   endtask

   task automatic test_arbitration;
      int   grants[$];
      logic exp_g[4];
`ifdef ALU_ARB_RR_EN
      exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      do_reset;
      req0_a_i = 8'h01; req0_b_i = 8'h01; req0_op_i = OpAdd;
      req1_a_i = 8'h02; req1_b_i = 8'h02; req1_op_i = OpAdd;
      req0_valid_i = 1'b1; req1_valid_i = 1'b1;
      rsp0_ready_i = 1'b1; rsp1_ready_i = 1'b1;
      for (int c = 0; c < 40 && grants.size() < 4; c++) begin
         @(negedge clk);
         if (req0_ready_o) grants.push_back(0);
         else if (req1_ready_o) grants.push_back(1);
         tick;
      end
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      repeat (5) tick;
      rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
      checks++;
      if (grants.size() != 4) begin
         errors++;
         $display("FAIL arb_count: got %0d grants required 4", grants.size());
      end
      for (int i = 0; i < grants.size(); i++) begin
         checks++;
         if (grants[i] != int'(exp_g[i])) begin
            errors++;
            $display("FAIL arb_grant%0d: got %0d required %0d", i, grants[i], exp_g[i]);
         end
      end
   endtask

   task automatic test_backpressure;
      bit ok;
      int lat;
      issue(1'b0, 8'h33, 8'h11, OpSub, ok);
      req1_a_i = 8'hF0; req1_b_i = 8'h3C; req1_op_i = OpAnd; req1_valid_i = 1'b1;
      wait_rsp(1'b0, lat);
      checks++;
      if (!ok || lat != 3) begin
         errors++;
         $display("FAIL bp_latency: got ok=%0d lat=%0d required 1 3", ok, lat);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (rsp0_valid_o !== 1'b1 || rsp0_result_o !== 8'h22 || rsp0_flags_o !== 3'b000 ||
             req1_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: got v=%b %h/%b r1rdy=%b required 1 22/000 0", i,
                     rsp0_valid_o, rsp0_result_o, rsp0_flags_o, req1_ready_o);
         end
      end
      checks++;
      if (req1_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_hs_ready1: got %b required 0", req1_ready_o);
      end
      consume(1'b0);
      @(negedge clk);
      checks++;
      if (req1_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL bp_req1_accept: got rdy=%b busy=%b required 1 0", req1_ready_o, busy_o);
      end
      tick;
      req1_valid_i = 1'b0;
      wait_rsp(1'b1, lat);
      checks++;
      if (lat != 3 || rsp1_result_o !== 8'h30 || rsp1_flags_o !== 3'b000) begin
         errors++;
         $display("FAIL bp_req1_rsp: got lat=%0d %h/%b required 3 30/000",
                  lat, rsp1_result_o, rsp1_flags_o);
      end
      consume(1'b1);
   endtask

   task automatic test_reset_mid;
      bit ok;
      int lat;
      issue(1'b0, 8'h81, 8'h01, OpShl, ok);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (!ok || busy_o !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_exec: got ok=%0d busy=%b required 1 1", ok, busy_o);
      end
      tick;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (rsp0_valid_o !== 1'b0 || rsp1_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_norsp%0d: got v0=%b v1=%b busy=%b required 0 0 0", i,
                     rsp0_valid_o, rsp1_valid_o, busy_o);
         end
      end
      tick;
      issue(1'b0, 8'h81, 8'h01, OpShl, ok);
      wait_rsp(1'b0, lat);
      checks++;
      if (!ok || lat != 3 || rsp0_result_o !== 8'h02 || rsp0_flags_o !== 3'b000) begin
         errors++;
         $display("FAIL rstmid_shl: got ok=%0d lat=%0d %h/%b required 1 3 02/000",
                  ok, lat, rsp0_result_o, rsp0_flags_o);
      end
      consume(1'b0);
   endtask

   task automatic test_random;
      bit           last = 1'b1;  // requester granted most recently
      bit           win;
      int           pat, lat;
      logic [W-1:0] a[2], b[2], res;
      logic [2:0]   op[2], flg;
      do_reset;
      for (int it = 0; it < 30; it++) begin
         pat = $urandom_range(1, 3);
         for (int r = 0; r < 2; r++) begin
            a[r] = W'($urandom); b[r] = W'($urandom); op[r] = 3'($urandom);
         end
         if (pat == 1) win = 1'b0;
         else if (pat == 2) win = 1'b1;
`ifdef ALU_ARB_RR_EN
         else win = ~last;
`else
         else win = 1'b0;
`endif
         req0_a_i = a[0]; req0_b_i = b[0]; req0_op_i = op[0]; req0_valid_i = pat[0];
         req1_a_i = a[1]; req1_b_i = b[1]; req1_op_i = op[1]; req1_valid_i = pat[1];
         @(negedge clk);
         checks++;
         if (req0_ready_o !== !win || req1_ready_o !== win) begin
            errors++;
            $display("FAIL rnd_grant%0d: got rdy=%b%b required winner %0d", it,
                     req1_ready_o, req0_ready_o, win);
         end
         tick;
         req0_valid_i = 1'b0; req1_valid_i = 1'b0;
         last = win;
         wait_rsp(win, lat);
         checks++;
         if (lat != 3 || (win ? rsp0_valid_o : rsp1_valid_o) !== 1'b0) begin
            errors++;
            $display("FAIL rnd_latency%0d: got %0d required 3 to owner %0d only", it, lat, win);
         end
         res = alu_fn(a[win], b[win], op[win]) & {W{1'b1}};
         flg = exp_flags(a[win], b[win], op[win]);
         checks++;
         if ((win ? rsp1_result_o : rsp0_result_o) !== res ||
             (win ? rsp1_flags_o : rsp0_flags_o) !== flg) begin
            errors++;
            $display("FAIL rnd_rsp%0d: got %h/%b required %h/%b", it,
                     win ? rsp1_result_o : rsp0_result_o, win ? rsp1_flags_o : rsp0_flags_o,
                     res, flg);
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         consume(win);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      req0_valid_i = 1'b0; req1_valid_i = 1'b0;
      req0_a_i = '0; req0_b_i = '0; req0_op_i = '0;
      req1_a_i = '0; req1_b_i = '0; req1_op_i = '0;
      rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
      test_reset;
      test_add;
      test_sub_zero;
      test_arbitration;
      test_backpressure;
      test_reset_mid;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
